// File: rtl/division_pkg.sv
// Shared definitions for the multiply/divide pair: FSM encoding and default operand width.
package division_pkg;

  localparam int DEF_WIDTH = 7;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_ADD  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/dividend_reconstruct_if.sv
// Request/result bundle for dividend_reconstruct; the master issues operands, the slave returns the result.
interface dividend_reconstruct_if
  import division_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic                 start;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     remainder;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   dividend;
  logic                 overflow;
  logic                 invalid;

  modport master (
    output start, quotient, divisor, remainder,
    input  busy, done, dividend, overflow, invalid
  );

  modport slave (
    input  start, quotient, divisor, remainder,
    output busy, done, dividend, overflow, invalid
  );

endinterface

// File: rtl/dividend_reconstruct.sv
// Rebuilds dividend = quotient*divisor + remainder by repeated addition, one add per clock.
module dividend_reconstruct
  import division_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [WIDTH-1:0]     quotient,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     remainder,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   dividend,
  output logic                 overflow,
  output logic                 invalid
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W  = '0;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     div_q, div_d;
  logic [2*WIDTH-1:0]   dividend_q, dividend_d;
  logic                 overflow_q, overflow_d;
  logic                 invalid_q, invalid_d;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    dividend_d = dividend_q;
    overflow_d = overflow_q;
    invalid_d  = invalid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          div_d = divisor;
          acc_d = {ZERO_W, remainder};
          cnt_d = quotient;
          if (divisor == ZERO_W || remainder >= divisor) begin
            state_d    = S_DONE;
            dividend_d = '0;
            overflow_d = 1'b0;
            invalid_d  = 1'b1;
          end else begin
            state_d = S_ADD;
          end
        end
      end
      S_ADD: begin
        if (cnt_q != ZERO_W) begin
          acc_d = acc_q + {ZERO_W, div_q};
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          // Anything in the upper half means the result no longer fits in WIDTH bits.
          state_d    = S_DONE;
          dividend_d = acc_q;
          overflow_d = |acc_q[2*WIDTH-1:WIDTH];
          invalid_d  = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      div_q      <= '0;
      dividend_q <= '0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values of the others.
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      dividend_q <= dividend_d;
      overflow_q <= overflow_d;
      invalid_q  <= invalid_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign dividend = dividend_q;
  assign overflow = overflow_q;
  assign invalid  = invalid_q;

endmodule

// File: tb/tb_dividend_reconstruct.sv
// Directed plus randomized checks of dividend_reconstruct against an arithmetic reference model.
module tb_dividend_reconstruct;
  import division_pkg::*;

  localparam int W      = DEF_WIDTH;
  localparam int BUDGET = 300;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   prev_div = 0;

  dividend_reconstruct_if #(.WIDTH(W)) bus ();

  dividend_reconstruct #(.WIDTH(W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .start     (bus.start),
    .quotient  (bus.quotient),
    .divisor   (bus.divisor),
    .remainder (bus.remainder),
    .busy      (bus.busy),
    .done      (bus.done),
    .dividend  (bus.dividend),
    .overflow  (bus.overflow),
    .invalid   (bus.invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One request: the model is plain arithmetic on the operands; latency is counted in edges after capture.
  task automatic run_op(input int q, input int d, input int r, input bit b2b, input bit tail,
                        input string tag);
    int exp_div;
    int exp_lat;
    bit exp_inv;
    bit exp_ovf;
    int k;
    exp_inv = (d == 0) || (r >= d);
    exp_div = exp_inv ? 0 : q * d + r;
    exp_ovf = exp_div > (2 ** W - 1);
    exp_lat = exp_inv ? 0 : q + 1;

    bus.quotient  = W'(q);
    bus.divisor   = W'(d);
    bus.remainder = W'(r);
    bus.start     = 1'b1;
    if (b2b) begin
      @(posedge clk);
      #1;
      check({tag, "_b2b_not_taken"}, 32'(bus.busy), 0);
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.quotient  = W'($urandom);
    bus.divisor   = W'($urandom);
    bus.remainder = W'($urandom);

    k = 0;
    @(negedge clk);
    if (!exp_inv) begin
      check({tag, "_busy"}, 32'(bus.busy), 1);
      check({tag, "_hold"}, 32'(bus.dividend), prev_div);
    end
    while (!bus.done && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"},  k, exp_lat);
    check({tag, "_dividend"}, 32'(bus.dividend), exp_div);
    check({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
    check({tag, "_invalid"},  32'(bus.invalid),  32'(exp_inv));
    check({tag, "_done_busy"}, 32'(bus.busy), 1);
    prev_div = exp_div;
    if (tail) begin
      @(negedge clk);
      check({tag, "_one_pulse"}, 32'(bus.done), 0);
      check({tag, "_idle"},      32'(bus.busy), 0);
      check({tag, "_keep"},      32'(bus.dividend), exp_div);
    end
  endtask

  initial begin
    int  done_cnt;
    int  first_k;
    int  first_div;
    int  q;
    int  d;
    int  r;
    bit  tail;
    bit  last_tail;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.quotient  = '0;
    bus.divisor   = '0;
    bus.remainder = '0;
    #2;
    check("reset_busy",     32'(bus.busy), 0);
    check("reset_done",     32'(bus.done), 0);
    check("reset_dividend", 32'(bus.dividend), 0);
    check("reset_overflow", 32'(bus.overflow), 0);
    check("reset_invalid",  32'(bus.invalid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(5, 7, 3, 1'b0, 1'b1, "q5_d7_r3");
    run_op(0, 9, 4, 1'b0, 1'b1, "q0_d9_r4");
    run_op(127, 127, 126, 1'b0, 1'b1, "max");
    run_op(3, 5, 5, 1'b0, 1'b1, "r_eq_d");
    run_op(3, 0, 0, 1'b0, 1'b1, "d_zero");
    run_op(1, 126, 1, 1'b0, 1'b1, "at_limit");
    run_op(1, 127, 1, 1'b0, 1'b0, "over_limit");
    run_op(1, 3, 2, 1'b1, 1'b1, "start_in_done");

    // Second request raised mid-computation with different operands must be dropped.
    bus.quotient  = W'(4);
    bus.divisor   = W'(2);
    bus.remainder = W'(1);
    bus.start     = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    done_cnt  = 0;
    first_k   = -1;
    first_div = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start     = 1'b1;
        bus.quotient  = W'(6);
        bus.divisor   = W'(5);
        bus.remainder = W'(0);
      end
      if (k == 3) bus.start = 1'b0;
      if (bus.done) begin
        done_cnt++;
        if (first_k < 0) begin
          first_k   = k;
          first_div = int'(bus.dividend);
        end
      end
    end
    check("ignore_start_pulses",   done_cnt, 1);
    check("ignore_start_latency",  first_k, 5);
    check("ignore_start_dividend", first_div, 9);
    prev_div = 9;

    // Reset in the middle of a long run: no completion, everything cleared.
    bus.quotient  = W'(10);
    bus.divisor   = W'(3);
    bus.remainder = W'(1);
    bus.start     = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy",     32'(bus.busy), 0);
    check("abort_done",     32'(bus.done), 0);
    check("abort_dividend", 32'(bus.dividend), 0);
    check("abort_overflow", 32'(bus.overflow), 0);
    check("abort_invalid",  32'(bus.invalid), 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    prev_div = 0;
    run_op(2, 3, 1, 1'b0, 1'b1, "after_reset");

    last_tail = 1'b1;
    for (int i = 0; i < 24; i++) begin
      q = $urandom_range(0, 12);
      d = $urandom_range(0, 127);
      if ($urandom_range(0, 5) == 0 || d == 0) r = $urandom_range(0, 127);
      else r = $urandom_range(0, d - 1);
      tail = 1'(($urandom_range(0, 1)) | ((i == 23) ? 1 : 0));
      run_op(q, d, r, !last_tail, tail, $sformatf("rand%0d", i));
      last_tail = tail;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
